fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of the instruction memory and directly downstream of nothing but the control FSM. It owns the program counter and drives the memory address. It registers the combinationally returned 8-bit instruction into an output instruction register with a valid/ready handshake toward decode. It also accepts branch/jump redirects from execute.

## Interface
Parameters:
- ADDR_W, 8, program counter / memory address width
- DATA_W, 8, instruction width
- IMEM_DEPTH, 32, number of implemented instruction words; power of two, ≤ 2^ADDR_W
- RESET_PC, 0, PC value after reset

Ports:
- clk  input  1  single clock, all state updates on rising edge
- clear  input  1  reset, synchronous, active-low (0 at a rising edge resets)
- start  input  1  begin fetching from current PC (sampled in IDLE only)
- address  output  ADDR_W  instruction memory address, combinationally equal to PC
- instruction  input  DATA_W  word returned combinationally by instruction memory for `address`
- ir  output  DATA_W  registered instruction toward decode
- ir_pc  output  ADDR_W  address `ir` was fetched from
- ir_valid  output  1  `ir`/`ir_pc` hold a live instruction
- ir_ready  input  1  decode accepts `ir` this cycle
- redirect  input  1  load PC from `redirect_pc`, flush held instruction
- redirect_pc  input  ADDR_W  redirect target
- done  output  1  program ran off the end of memory and drained

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset: PC=RESET_PC, ir=0, ir_pc=0, ir_valid=0, done=0, state IDLE; address=RESET_PC.
- Targets are used modulo IMEM_DEPTH (low log2(IMEM_DEPTH) bits, upper bits zero).
- IDLE:
  - start=1 → RUN; no fetch on that edge.
  - redirect=1 loads PC (preload); has priority over start, which is then ignored.
- RUN, with advance = !ir_valid || ir_ready:
  - redirect=1: PC←target, ir_valid←0. Any instruction accepted in the same cycle counts as consumed.
  - else if advance: ir←instruction, ir_pc←PC, ir_valid←1, PC←PC+1.
  - else: hold everything.
- End of memory: a load from PC=IMEM_DEPTH-1 leaves PC unchanged and moves to DRAIN.
- DRAIN:
  - ir_ready=1 → ir_valid←0, state DONE, done←1.
  - redirect → RUN with PC←target, ir_valid←0.
- DONE: done=1, ir_valid=0. start and redirect are ignored. Only reset leaves DONE.
- Reset mid-operation overrides all other inputs on that edge.

## Timing
- Fetch latency: the instruction at PC appears on `ir` one edge after advance is sampled.
- First valid instruction: ir_valid=1 two edges after the start edge (start edge → RUN, next edge → load).
- Sustained throughput: one instruction per cycle while ir_ready=1.
- Redirect bubble: one cycle with ir_valid=0. Target instruction is valid on the second edge after redirect.
- `address` changes only after clock edges. The memory's combinational path must settle within the cycle.
- done asserts on the edge where the last instruction is accepted.

## Configuration
- FETCH_WRAP_EN defined:
  - a load from IMEM_DEPTH-1 sets PC←0 and stays in RUN.
  - DRAIN/DONE are unreachable and done is tied 0.
- FETCH_WRAP_EN undefined: end-of-memory behaviour as in Operation.

## Structure
- Shared package fetch_pkg holds:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - ADDR_W/DATA_W/IMEM_DEPTH defaults
  - IMEM_LAST constant
- One sub-module: pc_counter. It covers PC register, increment, redirect load, modulo masking and wrap/end detect, with an `at_last` output. The FSM and instruction register stay in fetch_unit.

## Test plan
The bench models memory as 0xC1 at addresses 0–7, 0xC3 at 8–9, 0x00 elsewhere.
- Reset, start, ir_ready=1 held → ir = C1×8, C3, C3, then 00. ir_pc runs 0..31. done=1 the edge after ir_pc=31 is accepted. With FETCH_WRAP_EN: ir_pc 31 is followed by 0 (C1), and done stays 0.
- ir_ready=0 for 3 cycles while ir=C1, ir_pc=2 → ir/ir_pc/ir_valid hold and address holds 3. After ready: ir_pc=3, then 4.
- redirect=1, redirect_pc=8 while ir_pc=3 is valid → next cycle ir_valid=0, address=8. Following cycle ir=C3, ir_pc=8.
- redirect_pc=0x29 → PC=9, ir=C3, ir_pc=9.
- In DRAIN (ir_pc=31, ir_ready=0), redirect to 0 → RUN, then ir=C1, ir_pc=0, and done never asserts.
- clear=0 at the edge while ir_pc=5 → next cycle ir_valid=0, ir=0, address=0, state IDLE. Fetch does not resume until start.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and default geometry shared by the fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_IMEM_DEPTH = 32;
    localparam int IMEM_LAST      = DEF_IMEM_DEPTH - 1;
endpackage

// File: rtl/fetch_pc_counter.sv
// pc_counter: program counter with masked redirect load, increment and end-of-memory detect.
// FETCH_WRAP_EN makes the increment from the last word wrap to 0 instead of holding.
module pc_counter
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int RESET_PC   = 0
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_at_last
);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(IMEM_DEPTH - 1);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_inc;
    assign o_pc      = r_pc;
    assign o_at_last = r_pc == MASK;
`ifdef FETCH_WRAP_EN
    assign w_inc = o_at_last ? '0 : r_pc + ADDR_W'(1);
`else
    assign w_inc = o_at_last ? r_pc : r_pc + ADDR_W'(1);
`endif
    always_ff @(posedge clk) begin
        if (!clear)
            r_pc <= ADDR_W'(RESET_PC) & MASK;
        else if (i_load)
            r_pc <= i_target & MASK;
        else if (i_inc)
            r_pc <= w_inc;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC ownership, instruction register and valid/ready handoff to decode.
// FETCH_WRAP_EN: fetch wraps from the last word to 0 forever; done is tied 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int RESET_PC   = 0
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              done
);
    state_t r_state, w_next;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc, w_pc;
    logic r_ir_valid, w_at_last, w_advance;
    logic w_pc_load, w_pc_inc, w_ir_load, w_ir_clr;

    pc_counter #(.ADDR_W(ADDR_W), .IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk), .clear(clear), .i_load(w_pc_load), .i_inc(w_pc_inc),
        .i_target(redirect_pc), .o_pc(w_pc), .o_at_last(w_at_last)
    );

    assign w_advance = !r_ir_valid || ir_ready;

    always_comb begin
        w_next    = r_state;
        w_pc_load = 1'b0;
        w_pc_inc  = 1'b0;
        w_ir_load = 1'b0;
        w_ir_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pc_load = redirect;
                w_next    = !redirect && start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                w_pc_load = redirect;
                w_ir_clr  = redirect;
                w_ir_load = !redirect && w_advance;
                w_pc_inc  = w_ir_load;
`ifndef FETCH_WRAP_EN
                w_next    = w_ir_load && w_at_last ? S_DRAIN : S_RUN;
`endif
            end
            S_DRAIN: begin
                w_pc_load = redirect;
                w_ir_clr  = redirect || ir_ready;
                w_next    = redirect ? S_RUN : ir_ready ? S_DONE : S_DRAIN;
            end
            S_DONE: w_next = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // A redirect flushes the held word even if decode accepts it the same cycle.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_ir_load) begin
            r_ir       <= instruction;
            r_ir_pc    <= w_pc;
            r_ir_valid <= 1'b1;
        end else if (w_ir_clr) begin
            r_ir_valid <= 1'b0;
        end
    end

    assign address  = w_pc;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;
`ifdef FETCH_WRAP_EN
    assign done = 1'b0;
`else
    assign done = r_state == S_DONE;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan scenarios plus random traffic against a behavioural fetch model.
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int DEPTH = IMEM_LAST + 1;

    logic clk = 1'b0;
    logic clear, start, ir_ready, redirect;
    logic [7:0] redirect_pc, address, instruction, ir, ir_pc;
    logic ir_valid, done;

    int n_chk = 0;
    int n_pass = 0;

    int m_pc, m_ir, m_ir_pc;
    bit m_valid, m_started, m_draining, m_done;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_f(input logic [7:0] a);
        return a < 8'd8 ? 8'hC1 : a < 8'd10 ? 8'hC3 : 8'h00;
    endfunction

    assign instruction = mem_f(address);

    fetch_unit dut (
        .clk(clk), .clear(clear), .start(start), .address(address),
        .instruction(instruction), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: one call per rising edge, using the inputs the bench is driving.
    task automatic model_step();
        int tgt;
        tgt = int'(redirect_pc) % DEPTH;
        if (!clear) begin
            m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0;
            m_started = 0; m_draining = 0; m_done = 0;
        end else if (m_done) begin
        end else if (m_draining) begin
            if (redirect) begin
                m_pc = tgt; m_valid = 0; m_draining = 0;
            end else if (ir_ready) begin
                m_valid = 0; m_draining = 0; m_done = 1;
            end
        end else if (!m_started) begin
            if (redirect) m_pc = tgt;
            else if (start) m_started = 1;
        end else if (redirect) begin
            m_pc = tgt; m_valid = 0;
        end else if (!m_valid || ir_ready) begin
            m_ir = int'(mem_f(8'(m_pc)));
            m_ir_pc = m_pc;
            m_valid = 1;
            if (m_pc != DEPTH - 1) m_pc = m_pc + 1;
`ifdef FETCH_WRAP_EN
            else m_pc = 0;
`else
            else m_draining = 1;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("address", 32'(address), 32'(m_pc));
        chk("ir_valid", 32'(ir_valid), 32'(m_valid));
        chk("done", 32'(done), 32'(m_done));
        if (m_valid) begin
            chk("ir", 32'(ir), 32'(m_ir));
            chk("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
        end
    endtask

    task automatic do_reset();
        clear = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; ir_ready = 1'b1;
        tick();
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_ir_pc", 32'(ir_pc), 32'h0);
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_addr", 32'(address), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        clear = 1'b1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_bubble", 32'(ir_valid), 32'h0);
    endtask

    initial begin
        // full sweep of memory with decode always ready
        do_reset();
        begin_run();
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("sweep_pc", 32'(ir_pc), 32'(i));
            chk("sweep_ir", 32'(ir), 32'(i < 8 ? 8'hC1 : i < 10 ? 8'hC3 : 8'h00));
        end
        tick();
`ifdef FETCH_WRAP_EN
        chk("wrap_pc", 32'(ir_pc), 32'h0);
        chk("wrap_ir", 32'(ir), 32'hC1);
        chk("wrap_done", 32'(done), 32'h0);
`else
        chk("end_done", 32'(done), 32'h1);
        chk("end_valid", 32'(ir_valid), 32'h0);
        start = 1'b1; redirect = 1'b1; redirect_pc = 8'h04;
        tick();
        chk("done_sticky", 32'(done), 32'h1);
        start = 1'b0; redirect = 1'b0;
`endif

        // stall, redirect and masked redirect
        do_reset();
        begin_run();
        repeat (3) tick();
        chk("pre_stall_pc", 32'(ir_pc), 32'h2);
        ir_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_pc", 32'(ir_pc), 32'h2);
            chk("stall_ir", 32'(ir), 32'hC1);
            chk("stall_valid", 32'(ir_valid), 32'h1);
            chk("stall_addr", 32'(address), 32'h3);
        end
        ir_ready = 1'b1;
        tick();
        chk("unstall_pc", 32'(ir_pc), 32'h3);
        redirect = 1'b1; redirect_pc = 8'h08;
        tick();
        chk("redir_bubble", 32'(ir_valid), 32'h0);
        chk("redir_addr", 32'(address), 32'h8);
        redirect = 1'b0;
        tick();
        chk("redir_ir", 32'(ir), 32'hC3);
        chk("redir_pc", 32'(ir_pc), 32'h8);
        redirect = 1'b1; redirect_pc = 8'h29;
        tick();
        chk("mask_addr", 32'(address), 32'h9);
        redirect = 1'b0;
        tick();
        chk("mask_ir", 32'(ir), 32'hC3);
        chk("mask_pc", 32'(ir_pc), 32'h9);

        // redirect out of the drain phase
        redirect = 1'b1; redirect_pc = 8'd28;
        tick();
        redirect = 1'b0;
        repeat (4) tick();
        chk("drain_pc", 32'(ir_pc), 32'd31);
        ir_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h00;
        tick();
        chk("drain_redir_valid", 32'(ir_valid), 32'h0);
        chk("drain_redir_addr", 32'(address), 32'h0);
        redirect = 1'b0; ir_ready = 1'b1;
        tick();
        chk("drain_redir_ir", 32'(ir), 32'hC1);
        chk("drain_redir_pc", 32'(ir_pc), 32'h0);
        chk("drain_no_done", 32'(done), 32'h0);

        // reset mid-run, then preload in idle
        repeat (5) tick();
        chk("pre_clear_pc", 32'(ir_pc), 32'h5);
        clear = 1'b0; start = 1'b1; redirect = 1'b1; redirect_pc = 8'h07;
        tick();
        chk("clr_valid", 32'(ir_valid), 32'h0);
        chk("clr_ir", 32'(ir), 32'h0);
        chk("clr_addr", 32'(address), 32'h0);
        clear = 1'b1; start = 1'b0; redirect = 1'b0;
        repeat (2) tick();
        chk("idle_hold", 32'(ir_valid), 32'h0);
        redirect = 1'b1; redirect_pc = 8'h06; start = 1'b1;
        tick();
        chk("preload_addr", 32'(address), 32'h6);
        redirect = 1'b0; start = 1'b0;
        tick();
        chk("preload_idle", 32'(ir_valid), 32'h0);
        begin_run();
        tick();
        chk("preload_pc", 32'(ir_pc), 32'h6);

        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            clear       = $urandom_range(63) != 0;
            start       = $urandom_range(3) == 0;
            ir_ready    = $urandom_range(1) == 1;
            redirect    = $urandom_range(11) == 0;
            redirect_pc = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
